// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch queue between the instruction memory port and the ID stage.
// Keeps fetching while decode is held, retargets in one cycle on a taken redirect,
// and freezes completely whenever the global mem_ready_i stall is low.
module instr_prefetch_unit #(
  parameter int                 DEPTH      = 4,
  parameter int                 ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       mem_ready_i,
  input  logic [31:0]                instr_mem_data_i,
  output logic [ADDR_W-1:0]          instr_mem_addr_o,
  output logic                       instr_mem_rd_o,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_addr_i,
  input  logic                       id_ready_i,
  output logic                       id_valid_o,
  output logic [31:0]                id_instr_o,
  output logic [ADDR_W-1:0]          id_addr_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [31:0] NOP = 32'h00000013;

  logic [ADDR_W-1:0] pc;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     count;
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [31:0]       instr_q [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic redirect_take;

  // Occupancy flags and the handshake events for this cycle; fetch never looks at id_ready_i
  always_comb begin
    full           = (count == PW'(DEPTH));
    empty          = (count == '0);
    instr_mem_rd_o = rst_ni & ~full & ~redirect_i;
    push           = instr_mem_rd_o & mem_ready_i;
    pop            = ~empty & id_ready_i & mem_ready_i & ~redirect_i;
    redirect_take  = redirect_i & mem_ready_i;
  end

  // Head entry presented to decode; a NOP at address zero when the queue is empty
  always_comb begin
    instr_mem_addr_o = pc;
    id_valid_o       = ~empty;
    level_o          = count;
    id_instr_o       = NOP;
    id_addr_o        = '0;
    if (!empty) begin
      id_instr_o = instr_q[rd_ptr[IW-1:0]];
      id_addr_o  = addr_q[rd_ptr[IW-1:0]];
    end
  end

  // PC, pointers and count; reset beats redirect, redirect beats push/pop, stall freezes all
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc     <= RESET_ADDR;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_take) begin
      pc     <= {redirect_addr_i[ADDR_W-1:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + ADDR_W'(4);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents need no reset because count gates visibility
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      addr_q[wr_ptr[IW-1:0]]  <= pc;
      instr_q[wr_ptr[IW-1:0]] <= instr_mem_data_i;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed self-checking bench for instr_prefetch_unit (DEPTH 4); memory returns the address as data.
module tb_instr_prefetch_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_ready;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        id_ready;

  logic [31:0] mem_data;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_addr;
  logic [2:0]  level;

  logic [31:0] mem_data_hi;
  logic [31:0] mem_addr_hi;
  logic        mem_rd_hi;
  logic        id_valid_hi;
  logic [31:0] id_instr_hi;
  logic [31:0] id_addr_hi;
  logic [2:0]  level_hi;

  int assert_count = 0;
  int fail_count   = 0;

  assign mem_data    = mem_addr;
  assign mem_data_hi = mem_addr_hi;

  instr_prefetch_unit #(.DEPTH(4), .ADDR_W(32), .RESET_ADDR(32'h0)) u_dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .mem_ready_i      (mem_ready),
    .instr_mem_data_i (mem_data),
    .instr_mem_addr_o (mem_addr),
    .instr_mem_rd_o   (mem_rd),
    .redirect_i       (redirect),
    .redirect_addr_i  (redirect_addr),
    .id_ready_i       (id_ready),
    .id_valid_o       (id_valid),
    .id_instr_o       (id_instr),
    .id_addr_o        (id_addr),
    .level_o          (level)
  );

  instr_prefetch_unit #(.DEPTH(4), .ADDR_W(32), .RESET_ADDR(32'hFFFFFFF8)) u_dut_hi (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .mem_ready_i      (mem_ready),
    .instr_mem_data_i (mem_data_hi),
    .instr_mem_addr_o (mem_addr_hi),
    .instr_mem_rd_o   (mem_rd_hi),
    .redirect_i       (redirect),
    .redirect_addr_i  (redirect_addr),
    .id_ready_i       (id_ready),
    .id_valid_o       (id_valid_hi),
    .id_instr_o       (id_instr_hi),
    .id_addr_o        (id_addr_hi),
    .level_o          (level_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic mr, input logic redir,
                               input logic [31:0] raddr, input logic idr);
    rst_n         = rst;
    mem_ready     = mr;
    redirect      = redir;
    redirect_addr = raddr;
    id_ready      = idr;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
    end
  endtask

  task automatic checkHead(input string tag, input logic [31:0] addr, input logic [2:0] lvl);
    checkOutput({tag, "_valid"}, {31'b0, id_valid}, 32'd1);
    checkOutput({tag, "_addr"}, id_addr, addr);
    checkOutput({tag, "_instr"}, id_instr, addr);
    checkOutput({tag, "_level"}, {29'b0, level}, {29'b0, lvl});
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, "_valid"}, {31'b0, id_valid}, 32'd0);
    checkOutput({tag, "_level"}, {29'b0, level}, 32'd0);
    checkOutput({tag, "_instr"}, id_instr, 32'h00000013);
    checkOutput({tag, "_addr"}, id_addr, 32'd0);
  endtask

  initial begin
    // Reset held: queue empty, no fetch request
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    step();
    checkEmpty("rst");
    checkOutput("rst_pc", mem_addr, 32'h0);
    checkOutput("rst_rd", {31'b0, mem_rd}, 32'd0);
    checkOutput("rst_pc_hi", mem_addr_hi, 32'hFFFFFFF8);

    // Release: first cycle fetches at the reset address
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("rel_rd", {31'b0, mem_rd}, 32'd1);
    checkOutput("rel_pc", mem_addr, 32'h0);
    step();
    checkHead("s1", 32'h0, 3'd1);
    checkOutput("hi_pc1", mem_addr_hi, 32'hFFFFFFFC);
    checkOutput("hi_head1", id_addr_hi, 32'hFFFFFFF8);
    step();
    checkHead("s2", 32'h4, 3'd1);
    checkOutput("hi_pc2", mem_addr_hi, 32'h00000000);
    checkOutput("hi_head2", id_addr_hi, 32'hFFFFFFFC);
    for (int i = 3; i <= 20; i++) begin
      step();
      checkHead("stream", 32'(4 * (i - 1)), 3'd1);
    end

    // Fresh reset, then hold decode: queue fills to DEPTH and fetch stops
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    checkEmpty("rst2");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    checkHead("hz1", 32'h0, 3'd1);
    step();
    checkHead("hz2", 32'h0, 3'd2);
    step();
    checkHead("hz3", 32'h0, 3'd3);
    checkOutput("hz3_rd", {31'b0, mem_rd}, 32'd1);
    step();
    checkHead("hz4", 32'h0, 3'd4);
    checkOutput("hz4_rd", {31'b0, mem_rd}, 32'd0);
    step();
    checkHead("hz5", 32'h0, 3'd4);
    step();
    checkHead("hz6", 32'h0, 3'd4);
    checkOutput("hz6_rd", {31'b0, mem_rd}, 32'd0);
    checkOutput("hz6_pc", mem_addr, 32'h10);

    // Release decode: drain in order, fetch resumes the cycle after the first pop
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("drain_rd0", {31'b0, mem_rd}, 32'd0);
    step();
    checkHead("dr1", 32'h4, 3'd3);
    checkOutput("drain_rd1", {31'b0, mem_rd}, 32'd1);
    step();
    checkHead("dr2", 32'h8, 3'd3);
    step();
    checkHead("dr3", 32'hC, 3'd3);
    step();
    checkHead("dr4", 32'h10, 3'd3);

    // Redirect with three entries queued; low address bits dropped
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h103, 1'b1);
    checkOutput("redir_rd", {31'b0, mem_rd}, 32'd0);
    step();
    checkEmpty("redir1");
    checkOutput("redir1_pc", mem_addr, 32'h100);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    checkHead("redir2", 32'h100, 3'd1);
    checkOutput("redir2_pc", mem_addr, 32'h104);

    // Global stall with redirect and decode ready held high: nothing moves
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      checkHead("stall", 32'h100, 3'd1);
      checkOutput("stall_pc", mem_addr, 32'h104);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
    step();
    checkEmpty("unstall");
    checkOutput("unstall_pc", mem_addr, 32'h200);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    checkHead("unstall2", 32'h200, 3'd1);

    // Fill the queue, then a one-cycle reset with a redirect pending
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    checkHead("full", 32'h200, 3'd4);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h300, 1'b0);
    step();
    checkEmpty("rstfull");
    checkOutput("rstfull_pc", mem_addr, 32'h0);
    checkOutput("rstfull_rd", {31'b0, mem_rd}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("rstrel_rd", {31'b0, mem_rd}, 32'd1);
    step();
    checkHead("rstrel", 32'h0, 3'd1);
    checkOutput("rstrel_pc", mem_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
